// File: rtl/bitty_pkg.sv
// Shared definitions for the bitty fetch stage: instruction width and FSM states.
package bitty_pkg;

  localparam int INSTR_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2,
    HALT  = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/bitty_imem.sv
// Single-port synchronous program memory with registered read data.
// The array itself is never reset; only the read register is.
module bitty_imem #(
  parameter int W     = 16,
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  // Write port: contents persist across reset.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  // Read register: only loads on a read strobe so the output holds between reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/bitty_fetch.sv
// Instruction fetch stage feeding the bitty core one instruction at a time.
//
// Core handshake: run=1 means instr/pc are valid and held stable; the core
// raises done for one cycle when it has finished that instruction. done is
// only honoured while run is high (ISSUE), and may coincide with the first
// cycle of run. After done the stage drops run for one FETCH cycle.
module bitty_fetch #(
  parameter int INSTR_W = bitty_pkg::INSTR_W,
  parameter int DEPTH   = 256,
  parameter int AW      = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_en,
  input  logic [AW-1:0]      wr_addr,
  input  logic [INSTR_W-1:0] wr_data,
  output logic               wr_err,
  input  logic               start,
  input  logic               stop,
  input  logic [AW-1:0]      start_addr,
  input  logic [AW-1:0]      end_addr,
  input  logic               done,
  output logic [INSTR_W-1:0] instr,
  output logic               run,
  output logic [AW-1:0]      pc,
  output logic               busy,
  output logic               halted,
  output logic [15:0]        retired
);

  import bitty_pkg::*;

  fetch_state_t  state;
  logic [AW-1:0] end_q;
  logic          wr_ok;
  logic          rd_en;
  logic [AW-1:0] mem_addr;

  // Writes only land while the sequencer is parked; reads only happen in FETCH,
  // so the single port never sees both in the same cycle.
  assign wr_ok    = wr_en && ((state == IDLE) || (state == HALT));
  assign rd_en    = (state == FETCH) && !stop;
  assign mem_addr = wr_ok ? wr_addr : pc;

  bitty_imem #(
    .W     (INSTR_W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_imem (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wr_ok),
    .re    (rd_en),
    .addr  (mem_addr),
    .wdata (wr_data),
    .rdata (instr)
  );

  // Sequencer: state, PC, end address, retire counter and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      pc      <= '0;
      end_q   <= '0;
      retired <= '0;
      run     <= 1'b0;
      busy    <= 1'b0;
      halted  <= 1'b0;
      wr_err  <= 1'b0;
    end else begin
      wr_err <= wr_en && ((state == FETCH) || (state == ISSUE));
      if (stop) begin
        // Abort wins over start and done: nothing retires, pc stays put.
        state  <= IDLE;
        run    <= 1'b0;
        busy   <= 1'b0;
        halted <= 1'b0;
      end else begin
        case (state)
          IDLE, HALT: begin
            if (start) begin
              end_q   <= end_addr;
              pc      <= start_addr;
              retired <= '0;
              state   <= FETCH;
              busy    <= 1'b1;
              halted  <= 1'b0;
              run     <= 1'b0;
            end
          end
          FETCH: begin
            state <= ISSUE;
            run   <= 1'b1;
            busy  <= 1'b1;
          end
          ISSUE: begin
            if (done) begin
              if (retired != 16'hFFFF) retired <= retired + 16'd1;
              run <= 1'b0;
              if (pc == end_q) begin
                state  <= HALT;
                busy   <= 1'b0;
                halted <= 1'b1;
              end else begin
                // Width AW makes DEPTH-1 roll over to 0.
                pc    <= pc + AW'(1);
                state <= FETCH;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bitty_fetch.sv
// Bench for bitty_fetch: a program-memory model plus a per-run scoreboard of
// (pc, instr) episodes, a simple core responder, and directed scenarios.
module tb_bitty_fetch;

  localparam int AW = 8;
  localparam int IW = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          wr_en, start, stop, done;
  logic [AW-1:0] wr_addr, start_addr, end_addr, pc;
  logic [IW-1:0] wr_data, instr;
  logic          wr_err, run, busy, halted;
  logic [15:0]   retired;

  logic core_done = 1'b0;
  logic man_done  = 1'b0;
  assign done = core_done | man_done;

  bitty_fetch dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_err     (wr_err),
    .start      (start),
    .stop       (stop),
    .start_addr (start_addr),
    .end_addr   (end_addr),
    .done       (done),
    .instr      (instr),
    .run        (run),
    .pc         (pc),
    .busy       (busy),
    .halted     (halted),
    .retired    (retired)
  );

  // ---------------- scoreboard state ----------------
  int vectors = 0;
  int miscompares = 0;
  logic [AW+IW-1:0] exp_q[$];
  logic [AW-1:0]    seen_pc[$];
  logic [IW-1:0]    seen_instr[$];
  logic [IW-1:0]    model_mem[256];
  int               core_lat = 3;
  bit               core_en = 1'b1;
  int               core_cnt = 0;
  bit               hit;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- core responder ----------------
  // Raises done core_lat cycles after run rises (0 = same cycle).
  always begin
    @(posedge clk);
    #1;
    if (!rst_n || !run) begin
      core_done = 1'b0;
      core_cnt  = 0;
    end else begin
      core_done = core_en && (core_cnt == core_lat);
      core_cnt++;
    end
  end

  // ---------------- compare process ----------------
  logic [AW+IW-1:0] cur;
  logic [IW-1:0]    held = '0;
  bit               run_q = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      run_q = 1'b0;
      held  = '0;
    end else begin
      if (run && !run_q) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_run", 32'd1, 32'd0);
        end else begin
          cur = exp_q.pop_front();
          chk("issue_pc", 32'(pc), 32'(cur[AW+IW-1:IW]));
          chk("issue_instr", 32'(instr), 32'(cur[IW-1:0]));
          seen_pc.push_back(pc);
          seen_instr.push_back(instr);
        end
      end else if (run) begin
        chk("run_pc_stable", 32'(pc), 32'(cur[AW+IW-1:IW]));
        chk("run_instr_stable", 32'(instr), 32'(cur[IW-1:0]));
      end else begin
        chk("instr_hold", 32'(instr), 32'(held));
      end
      held  = instr;
      run_q = run;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wr(input int a, input logic [IW-1:0] d);
    wr_en = 1'b1; wr_addr = AW'(a); wr_data = d;
    tick();
    wr_en = 1'b0;
    model_mem[a] = d;
  endtask

  task automatic start_run(input int s, input int e, input int lat);
    int n;
    n = ((e - s + 256) % 256) + 1;
    core_lat = lat;
    seen_pc.delete();
    seen_instr.delete();
    for (int k = 0; k < n; k++) begin
      int a;
      a = (s + k) % 256;
      exp_q.push_back({AW'(a), model_mem[a]});
    end
    start_addr = AW'(s); end_addr = AW'(e); start = 1'b1;
    tick();
    start = 1'b0;
    chk("fetch_status", 32'({busy, run, halted}), 32'b100);
    chk("fetch_pc", 32'(pc), 32'(s));
    chk("start_clears_retired", 32'(retired), 32'd0);
    tick();
    chk("run_in_cycle2", 32'(run), 32'd1);
  endtask

  task automatic finish_run(input int n);
    int t;
    t = 0;
    while (!halted && t < 300) begin
      tick();
      t++;
    end
    chk("halt_reached", 32'(halted), 32'd1);
    chk("retired_count", 32'(retired), 32'(n));
    chk("halt_run_low", 32'({run, busy}), 32'd0);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    start = 1'b0; stop = 1'b0; start_addr = '0; end_addr = '0;
    tick(); tick();
    chk("rst_outputs", 32'({run, busy, halted, wr_err}), 32'd0);
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_instr", 32'(instr), 32'd0);
    chk("rst_retired", 32'(retired), 32'd0);
    rst_n = 1'b1;
    tick();

    // Linear run 0..3, core latency 3.
    for (int i = 0; i < 4; i++) wr(i, 16'hA000 + 16'(i));
    start_run(0, 3, 3);
    finish_run(4);
    chk("lin_count", 32'(seen_instr.size()), 32'd4);
    chk("lin_i0", 32'(seen_instr[0]), 32'h0000A000);
    chk("lin_i1", 32'(seen_instr[1]), 32'h0000A001);
    chk("lin_i2", 32'(seen_instr[2]), 32'h0000A002);
    chk("lin_i3", 32'(seen_instr[3]), 32'h0000A003);

    // Wrap-around 254..1 with done in the same cycle run rises.
    wr(254, 16'hC0FE); wr(255, 16'hC0FF); wr(0, 16'hC100); wr(1, 16'hC101);
    start_run(254, 1, 0);
    finish_run(4);
    chk("wrap_pc0", 32'(seen_pc[0]), 32'd254);
    chk("wrap_pc1", 32'(seen_pc[1]), 32'd255);
    chk("wrap_pc2", 32'(seen_pc[2]), 32'd0);
    chk("wrap_pc3", 32'(seen_pc[3]), 32'd1);

    // Write (and a stray start) while busy: dropped, wr_err pulses once.
    wr(4, 16'h4444); wr(5, 16'h5555); wr(6, 16'h6666);
    start_run(4, 6, 6);
    wr_en = 1'b1; wr_addr = 8'd5; wr_data = 16'hBEEF;
    start = 1'b1; start_addr = 8'd9;
    tick();
    wr_en = 1'b0; start = 1'b0;
    chk("busy_wr_err_pulse", 32'(wr_err), 32'd1);
    chk("busy_start_ignored", 32'(pc), 32'd4);
    tick();
    chk("busy_wr_err_clear", 32'(wr_err), 32'd0);
    finish_run(3);
    chk("busy_mem5_kept", 32'(seen_instr[1]), 32'h00005555);

    // Stop together with done at pc 2.
    core_en = 1'b0;
    start_run(0, 3, 0);
    hit = 1'b0;
    for (int i = 0; i < 60 && !hit; i++) begin
      if (run) begin
        if (pc == 8'd2) begin
          man_done = 1'b1; stop = 1'b1;
          tick();
          man_done = 1'b0; stop = 1'b0;
          hit = 1'b1;
        end else begin
          man_done = 1'b1;
          tick();
          man_done = 1'b0;
        end
      end else begin
        tick();
      end
    end
    chk("stop_reached", 32'(hit), 32'd1);
    chk("stop_idle", 32'({run, busy, halted}), 32'd0);
    chk("stop_pc", 32'(pc), 32'd2);
    chk("stop_retired", 32'(retired), 32'd2);
    exp_q.delete();
    core_en = 1'b1;
    tick();
    chk("stop_stays_idle", 32'({run, busy, halted}), 32'd0);

    // Asynchronous reset mid-ISSUE, then memory survives it.
    wr(0, 16'h1234);
    start_run(0, 3, 20);
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_outputs", 32'({run, busy, halted, wr_err}), 32'd0);
    chk("midrst_pc", 32'(pc), 32'd0);
    chk("midrst_instr", 32'(instr), 32'd0);
    chk("midrst_retired", 32'(retired), 32'd0);
    exp_q.delete();
    tick(); tick();
    rst_n = 1'b1;
    tick();
    start_run(0, 0, 2);
    finish_run(1);
    chk("mem_retained", 32'(seen_instr[0]), 32'h00001234);

    // Single instruction, then restart from HALT.
    wr(7, 16'h7777);
    start_run(7, 7, 1);
    finish_run(1);
    chk("single_episodes", 32'(seen_pc.size()), 32'd1);
    chk("single_instr", 32'(seen_instr[0]), 32'h00007777);
    start_run(0, 0, 1);
    finish_run(1);
    chk("restart_instr", 32'(seen_instr[0]), 32'h00001234);

    tick(); tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bitty_fetch.md
# bitty_fetch

Instruction fetch stage sitting directly upstream of the bitty CPU core. It holds a small program memory loaded over a simple write port (driven from the Wishbone/LA wrapper) and sequences one 16-bit instruction at a time into the core's `instr`/`run` inputs. It advances only when the core reports `done`, and stops at a programmed end address. It replaces the constant-zero instruction currently tied into the core.

## Interface
Parameters:
- `INSTR_W`, 16, instruction width; matches the core's `instr` port.
- `DEPTH`, 256, program memory depth in words; power of two.
- `AW`, $clog2(DEPTH), address/PC width.

Ports:
- `clk`  in  1  single clock for the whole block.
- `rst_n`  in  1  asynchronous, active-low reset.
- `wr_en`  in  1  program-memory write strobe.
- `wr_addr`  in  AW  write address.
- `wr_data`  in  INSTR_W  write data.
- `wr_err`  out  1  one-cycle pulse when a write is dropped because the block is busy.
- `start`  in  1  start pulse; latches `start_addr`/`end_addr`.
- `stop`  in  1  abort; returns to IDLE from any state.
- `start_addr`  in  AW  first PC.
- `end_addr`  in  AW  last PC executed, inclusive.
- `done`  in  1  from the core: current instruction completed.
- `instr`  out  INSTR_W  instruction to the core.
- `run`  out  1  to the core: `instr` is valid; execute it.
- `pc`  out  AW  address of the instruction currently presented.
- `busy`  out  1  high in FETCH or ISSUE.
- `halted`  out  1  high in HALT.
- `retired`  out  16  count of completed instructions since the last `start`; saturates at 16'hFFFF.

## Operation
- FSM states: IDLE, FETCH, ISSUE, HALT.
- IDLE: on `start`, latch `end_addr`, set `pc` = `start_addr`, clear `retired`, go to FETCH.
- FETCH: the memory read is in flight for one cycle; go to ISSUE.
- ISSUE: `run`=1 and `instr` = mem[`pc`], both held stable until `done` is sampled high.
  - On `done`, `retired` increments.
  - If `pc` == `end_addr`, go to HALT.
  - Otherwise `pc` = `pc`+1 modulo DEPTH, then go to FETCH.
- HALT: `halted`=1 and `run`=0. On `start`, begin a new run exactly as from IDLE.
- `stop` in any state goes to IDLE next cycle. `stop` has priority over `start` and `done` in the same cycle; the instruction is not retired and the PC does not advance.
- `start` is ignored in FETCH and ISSUE.
- `done` is ignored outside ISSUE.
- Writes are accepted only in IDLE or HALT: mem[`wr_addr`] = `wr_data`. In FETCH or ISSUE the write is dropped and `wr_err` pulses the next cycle.
- PC wrap-around: DEPTH-1 wraps to 0. A run with `end_addr` < `start_addr` executes through the wrap.
- If `start_addr` == `end_addr`, exactly one instruction is executed.
- Memory contents are not reset. They are undefined until written.

## Timing
- Reset values (asynchronous, on `rst_n` low):
  - state IDLE; `pc`=0, `instr`=0, `retired`=0.
  - `run`, `busy`, `halted` and `wr_err` are 0.
- `start` in cycle 0 gives FETCH in cycle 1 and ISSUE (`run`=1) in cycle 2.
- `done` in cycle n (in ISSUE):
  - `pc` advances and the state is FETCH in n+1; `run`=0.
  - ISSUE with the next instruction in n+2.
  - Net overhead is 2 cycles per instruction beyond core latency.
- `done` high in the same cycle `run` first rises is legal and retires that instruction.
- The memory read is synchronous, one cycle, and is registered into `instr`.
- `instr` keeps its last value outside ISSUE.
- Memory write takes effect at the clock edge. The read-during-write case cannot occur, because writes are only accepted when the block is idle.
- `rst_n` asserted mid-run aborts immediately. The program memory is retained.

## Structure
- Shared package `bitty_pkg`: `INSTR_W`, the state enum `fetch_state_t` {IDLE, FETCH, ISSUE, HALT}.
- Sub-module `bitty_imem`: single-port synchronous RAM, DEPTH×INSTR_W, with write enable and registered read data.
- Top `bitty_fetch` holds the FSM, PC, end-address register, `retired` counter and write gating.

## Test plan
- Reset and idle:
  - Assert `rst_n`=0 mid-ISSUE: all outputs go to their reset values, `pc`=0.
  - After release, a prior write of mem[0]=16'h1234 reads back as `instr` on a `start_addr`=0 run.
- Linear run:
  - Load mem[0..3] = 16'hA000..16'hA003; `start`, `start_addr`=0, `end_addr`=3; core model asserts `done` 3 cycles after `run`.
  - Required: the four instrs are presented in order, `run` first rises in cycle 2, `retired`=4, `halted`=1.
- Wrap-around:
  - `start_addr`=254, `end_addr`=1, DEPTH=256.
  - Required: `pc` sequence 254, 255, 0, 1, then HALT with `retired`=4.
- Write while busy:
  - `wr_en` with addr 5, data 16'hBEEF during ISSUE.
  - Required: `wr_err` pulses once and mem[5] is unchanged.
- Stop priority:
  - `stop` and `done` asserted together in ISSUE at `pc`=2.
  - Required: state IDLE, `retired` not incremented, `pc` stays 2.
- Single instruction and restart:
  - `start_addr`=`end_addr`=7 gives exactly one `run` episode and then HALT.
  - A second `start` from HALT with `start_addr`=0 clears `retired` to 0 and restarts.
